// File: rtl/digit_pkg.sv
// Shared types and constants for the digit detector: FSM states, bus widths, defaults.
package digit_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned ACT_W  = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned IDX_W  = 4;

  localparam int unsigned DEF_BASE_ADDR = 8;
  localparam int unsigned DEF_NUM_OUT   = 10;
  localparam int unsigned DEF_THRESHOLD = 4;

  localparam logic [DIGIT_W-1:0] REJECT_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/digit_detector_if.sv
// Network-controller / sigmoid-file / result bus seen by the digit detector.
interface digit_detector_if;
  import digit_pkg::*;

  logic               network_done;
  logic               network_calc;
  logic [ACT_W-1:0]   sigmoid_rdata;
  logic [ADDR_W-1:0]  sigmoid_rd_addr;
  logic               busy;
  logic [DIGIT_W-1:0] digit;
  logic [ACT_W-1:0]   confidence;
  logic               digit_valid;

  // Driver side: network controller, sigmoid register file, result consumer.
  modport master (
    output network_done, network_calc, sigmoid_rdata,
    input  sigmoid_rd_addr, busy, digit, confidence, digit_valid
  );

  // Detector side.
  modport slave (
    input  network_done, network_calc, sigmoid_rdata,
    output sigmoid_rd_addr, busy, digit, confidence, digit_valid
  );
endinterface

// File: rtl/digit_detector.sv
// Scans output-neuron activations after each network run and reports the argmax.
// Optional build macro DIGIT_DETECTOR_THRESHOLD_EN rejects weak winners with digit 4'hF.
module digit_detector
  import digit_pkg::*;
#(
  parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned NUM_OUT   = DEF_NUM_OUT,
  parameter int unsigned THRESHOLD = DEF_THRESHOLD
) (
  input  logic             clk,
  input  logic             n_rst,
  digit_detector_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR0    = ADDR_W'(BASE_ADDR);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_OUT - 1);

  if (NUM_OUT < 1 || NUM_OUT > 16 || THRESHOLD > 16 || (BASE_ADDR + NUM_OUT) > 32) begin : g_param_check
    $error("digit_detector: illegal parameter combination");
  end

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [ACT_W-1:0]   run_max;
  logic [IDX_W-1:0]   run_idx;
  logic               done_q;
  logic [ADDR_W-1:0]  rd_addr;
  logic               busy;
  logic [DIGIT_W-1:0] digit;
  logic [ACT_W-1:0]   confidence;
  logic               digit_valid;

  logic               start_c;
  logic [ACT_W-1:0]   new_max_c;
  logic [IDX_W-1:0]   new_idx_c;
  logic [DIGIT_W-1:0] report_digit_c;

  // Strictly-greater update keeps the lowest index on ties.
  always_comb begin
    start_c   = (state == IDLE) && bus.network_done && !done_q && !bus.network_calc;
    new_max_c = run_max;
    new_idx_c = run_idx;
    if (bus.sigmoid_rdata > run_max) begin
      new_max_c = bus.sigmoid_rdata;
      new_idx_c = idx;
    end
`ifdef DIGIT_DETECTOR_THRESHOLD_EN
    report_digit_c = (new_max_c < ACT_W'(THRESHOLD)) ? REJECT_DIGIT : DIGIT_W'(new_idx_c);
`else
    report_digit_c = DIGIT_W'(new_idx_c);
`endif
  end

  // Result is latched on the last scan edge so it is already stable during REPORT.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      idx         <= '0;
      run_max     <= '0;
      run_idx     <= '0;
      done_q      <= 1'b1;
      rd_addr     <= '0;
      busy        <= 1'b0;
      digit       <= '0;
      confidence  <= '0;
      digit_valid <= 1'b0;
    end else begin
      done_q      <= bus.network_done;
      digit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_c) begin
            state   <= SCAN;
            idx     <= '0;
            run_max <= '0;
            run_idx <= '0;
            busy    <= 1'b1;
            rd_addr <= ADDR0;
          end
        end
        SCAN: begin
          if (bus.network_calc) begin
            state   <= IDLE;
            busy    <= 1'b0;
            rd_addr <= '0;
          end else begin
            run_max <= new_max_c;
            run_idx <= new_idx_c;
            if (idx == LAST_IDX) begin
              state       <= REPORT;
              rd_addr     <= '0;
              digit       <= report_digit_c;
              confidence  <= new_max_c;
              digit_valid <= 1'b1;
            end else begin
              idx     <= idx + IDX_W'(1);
              rd_addr <= rd_addr + ADDR_W'(1);
            end
          end
        end
        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          rd_addr <= '0;
        end
      endcase
    end
  end

  assign bus.sigmoid_rd_addr = rd_addr;
  assign bus.busy            = busy;
  assign bus.digit           = digit;
  assign bus.confidence      = confidence;
  assign bus.digit_valid     = digit_valid;

endmodule

// File: tb/tb_digit_detector.sv
// Directed bench for digit_detector: latency, argmax/tie rules, abort, edge and reset handling.
module tb_digit_detector;

  logic clk;
  logic n_rst;
  logic [3:0] mem [32];

  int checks;
  int errors;

  digit_detector_if bus ();

  digit_detector dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sigmoid register file model: combinational read.
  assign bus.sigmoid_rdata = mem[bus.sigmoid_rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] vals [10]);
    for (int i = 0; i < 32; i++) mem[i] = 4'hA;
    for (int i = 0; i < 10; i++) mem[8 + i] = vals[i];
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.network_done = 1'b1;
    bus.network_calc = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.digit_valid !== 1'b0 || bus.sigmoid_rd_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b valid=%b addr=%0d required 0/0/0", bus.busy, bus.digit_valid, bus.sigmoid_rd_addr);
    end
    checks++;
    if (bus.digit !== 4'd0 || bus.confidence !== 4'd0) begin
      errors++;
      $display("FAIL reset_result digit=%0d conf=%0d required 0/0", bus.digit, bus.confidence);
    end
    // network_done high through reset release must not start a scan
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_done_high cycle %0d busy=%b required 0", k, bus.busy);
      end
    end
  endtask

  // One full scan with cycle-exact address, busy and valid checks.
  task automatic run_scan(input logic [3:0] vals [10], input logic [3:0] exp_d,
                          input logic [3:0] exp_c, input string name);
    load(vals);
    bus.network_done = 1'b0;
    tick();
    bus.network_done = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k <= 10) begin
        checks++;
        if (bus.sigmoid_rd_addr !== 5'(7 + k) || bus.busy !== 1'b1 || bus.digit_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s scan k=%0d addr=%0d busy=%b valid=%b required %0d/1/0",
                   name, k, bus.sigmoid_rd_addr, bus.busy, bus.digit_valid, 7 + k);
        end
      end else if (k == 11) begin
        checks++;
        if (bus.digit_valid !== 1'b1 || bus.busy !== 1'b1 || bus.sigmoid_rd_addr !== 5'd0) begin
          errors++;
          $display("FAIL %s report valid=%b busy=%b addr=%0d required 1/1/0",
                   name, bus.digit_valid, bus.busy, bus.sigmoid_rd_addr);
        end
        checks++;
        if (bus.digit !== exp_d || bus.confidence !== exp_c) begin
          errors++;
          $display("FAIL %s result digit=%0d conf=%0d required %0d/%0d",
                   name, bus.digit, bus.confidence, exp_d, exp_c);
        end
      end else begin
        checks++;
        if (bus.digit_valid !== 1'b0 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL %s after valid=%b busy=%b required 0/0", name, bus.digit_valid, bus.busy);
        end
      end
    end
  endtask

  task automatic test_argmax();
    logic [3:0] v [10];
    v = '{4'd1, 4'd2, 4'd3, 4'd9, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    run_scan(v, 4'd3, 4'd9, "argmax");
  endtask

  task automatic test_tie();
    logic [3:0] v [10];
    v = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7};
    run_scan(v, 4'd0, 4'd7, "tie");
  endtask

  task automatic test_last_index();
    logic [3:0] v [10];
    v = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15};
    run_scan(v, 4'd9, 4'd15, "last_index");
  endtask

  task automatic test_all_zero();
    logic [3:0] v [10];
    v = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    run_scan(v, 4'd0, 4'd0, "all_zero");
  endtask

  task automatic test_threshold();
    logic [3:0] v [10];
    v = '{4'd1, 4'd3, 4'd2, 4'd0, 4'd3, 4'd0, 4'd1, 4'd0, 4'd0, 4'd2};
`ifdef DIGIT_DETECTOR_THRESHOLD_EN
    run_scan(v, 4'hF, 4'd3, "threshold");
`else
    run_scan(v, 4'd1, 4'd3, "threshold");
`endif
  endtask

  task automatic test_abort();
    logic [3:0] v [10];
    int nvalid;
    v = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0};
    run_scan(v, 4'd5, 4'd8, "abort_pre");
    v = '{4'd0, 4'd14, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    load(v);
    bus.network_done = 1'b0;
    tick();
    bus.network_done = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    checks++;
    if (bus.sigmoid_rd_addr !== 5'd12 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_idx4 addr=%0d busy=%b required 12/1", bus.sigmoid_rd_addr, bus.busy);
    end
    bus.network_calc = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.sigmoid_rd_addr !== 5'd0 || bus.digit_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle busy=%b addr=%0d valid=%b required 0/0/0",
               bus.busy, bus.sigmoid_rd_addr, bus.digit_valid);
    end
    bus.network_calc = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (bus.digit_valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0 || bus.digit !== 4'd5 || bus.confidence !== 4'd8) begin
      errors++;
      $display("FAIL abort_keep valids=%0d digit=%0d conf=%0d required 0/5/8",
               nvalid, bus.digit, bus.confidence);
    end
  endtask

  task automatic test_edge_while_busy();
    logic [3:0] v [10];
    int nvalid;
    v = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd11, 4'd0, 4'd0, 4'd0};
    load(v);
    bus.network_done = 1'b0;
    tick();
    bus.network_done = 1'b1;
    nvalid = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.digit_valid === 1'b1) nvalid++;
      if (k == 3) bus.network_done = 1'b0;
      if (k == 4) bus.network_done = 1'b1;
    end
    checks++;
    if (nvalid != 1) begin
      errors++;
      $display("FAIL edge_busy valids=%0d required 1", nvalid);
    end
    checks++;
    if (bus.digit !== 4'd6 || bus.confidence !== 4'd11 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL edge_busy_result digit=%0d conf=%0d busy=%b required 6/11/0",
               bus.digit, bus.confidence, bus.busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    int nvalid;
    bus.network_done = 1'b0;
    tick();
    bus.network_done = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.sigmoid_rd_addr !== 5'd0 || bus.digit !== 4'd0 || bus.digit_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy=%b addr=%0d digit=%0d valid=%b required 0/0/0/0",
               bus.busy, bus.sigmoid_rd_addr, bus.digit, bus.digit_valid);
    end
    nvalid = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.digit_valid === 1'b1 || bus.busy === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet active_cycles=%0d required 0", nvalid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = 4'd0;
    n_rst = 1'b0;
    bus.network_done = 1'b1;
    bus.network_calc = 1'b0;
    test_reset();
    test_argmax();
    test_tie();
    test_last_index();
    test_all_zero();
    test_threshold();
    test_abort();
    test_edge_while_busy();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_detector.md
DIGIT_DETECTOR -- requirements
Module: digit_detector

Interface
- REQ-001 The block SHALL take parameter BASE_ADDR, default 8, the sigmoid-register address of output neuron 0.
- REQ-002 The block SHALL take parameter NUM_OUT, default 10, the number of output neurons scanned.
- REQ-003 The block SHALL take parameter THRESHOLD, default 4, the minimum accepted winning activation (used only under REQ-024).
- REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-005 Port n_rst, input, 1 bit: synchronous, active-low reset.
- REQ-006 Port network_done, input, 1 bit: level from the network controller; its rising edge starts a scan.
- REQ-007 Port network_calc, input, 1 bit: high while the network is computing; aborts a scan in progress.
- REQ-008 Port sigmoid_rdata, input, 4 bits: combinational read data of the sigmoid register file at sigmoid_rd_addr.
- REQ-009 Port sigmoid_rd_addr, output, 5 bits: sigmoid read address.
- REQ-010 Port busy, output, 1 bit: high while a scan is in progress; the top level uses it to steer the sigmoid read-address mux to this block.
- REQ-011 Port digit, output, 4 bits: index of the winning output neuron.
- REQ-012 Port confidence, output, 4 bits: activation of the winning neuron.
- REQ-013 Port digit_valid, output, 1 bit: one-cycle pulse when digit and confidence update.

Function
- REQ-014 The FSM SHALL have three states: IDLE, SCAN and REPORT.
- REQ-015 Start condition: network_done = 1 while the previous-cycle sample of network_done = 0, in IDLE, with network_calc = 0. On start the FSM SHALL go to SCAN, set idx = 0, and clear the running max to 0 and the running index to 0.
- REQ-016 In SCAN, sigmoid_rd_addr SHALL equal BASE_ADDR + idx (5-bit, no wrap for the defaults); sigmoid_rdata SHALL be sampled in the same cycle.
- REQ-017 Compare rule: the running max and index SHALL update only when sigmoid_rdata > running max (unsigned, strict), so on a tie the lowest index wins.
- REQ-018 At idx = NUM_OUT-1 the FSM SHALL go to REPORT; otherwise idx SHALL increment by 1.
- REQ-019 In REPORT: digit and confidence SHALL be loaded from the final max/index (including a greater value found in the last SCAN cycle), digit_valid = 1 for exactly that cycle, and the FSM SHALL then return to IDLE.
- REQ-020 Latency: with the start edge sampled in cycle N, SCAN occupies cycles N+1..N+NUM_OUT and digit_valid is high in cycle N+NUM_OUT+1 (N+11 for the defaults).
- REQ-021 busy SHALL be 1 exactly in SCAN and REPORT.
- REQ-022 sigmoid_rd_addr SHALL be 0 outside SCAN.
- REQ-023 Boundaries:
  - network_done edges while busy are ignored.
  - network_calc = 1 in SCAN or REPORT sends the FSM to IDLE next cycle with no digit_valid; digit and confidence keep their previous values.
  - network_done held high never restarts a scan (edge only).
  - All sigmoid_rdata = 0 gives digit = 0, confidence = 0.

Configuration
- REQ-024 When macro DIGIT_DETECTOR_THRESHOLD_EN is defined and the final max < THRESHOLD, REPORT SHALL set digit = 4'hF (reject) with confidence = the max; when it is not defined, no threshold logic is compiled and digit is always the argmax.

Reset
- REQ-025 When n_rst = 0 at a rising clk edge, the block SHALL enter IDLE and set idx = 0, running max and index = 0, digit = 0, confidence = 0, digit_valid = 0, busy = 0, sigmoid_rd_addr = 0.
- REQ-026 Reset SHALL set the network_done edge register to 1, so that network_done high out of reset (the controller's IDLE level) causes no start.
- REQ-027 Reset mid-scan SHALL discard the scan without producing digit_valid.

Structure
- REQ-028 Package digit_pkg SHALL hold the state enum (IDLE, SCAN, REPORT), the default NUM_OUT/BASE_ADDR constants and REJECT_DIGIT = 4'hF.
- REQ-029 There SHALL be no sub-module: the index counter is inline because the existing flex_counter uses an asynchronous reset.

Verification
- REQ-030 Sigmoid values at addresses 8..17 = {1,2,3,9,4,0,0,0,0,0}; network_done 0->1 -> sigmoid_rd_addr steps 8..17, digit_valid in cycle N+11, digit = 3, confidence = 9.
- REQ-031 Values {7,0,0,0,0,0,0,0,0,7} -> digit = 0, confidence = 7 (tie, lowest index wins).
- REQ-032 Values {0,...,0,15} (max at last index) -> digit = 9, confidence = 15.
- REQ-033 Abort: previous result digit = 5; network_calc = 1 at SCAN idx 4 -> IDLE next cycle, no digit_valid, digit stays 5.
- REQ-034 Edge handling: network_done high through reset release -> no scan; a second edge at idx 2 -> ignored, exactly one digit_valid.
- REQ-035 With DIGIT_DETECTOR_THRESHOLD_EN defined and all values ≤ 3 (max 3) -> digit = 4'hF, confidence = 3; without the macro -> digit = argmax.
